kpn_adder_firing_ctrl: RTL



---
 rtl/kpn_adder_firing_ctrl_pkg.sv | 14 +
 rtl/kpn_adder_firing_ctrl_if.sv | 29 ++
 rtl/kpn_adder_firing_ctrl_timer.sv | 30 +++
 rtl/kpn_adder_firing_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/kpn_adder_firing_ctrl_pkg.sv
// Shared constants for KPN node firing controllers.
// State encoding, default counter widths and latency-timer width.
package kpn_ctrl_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] READ    = 2'd1;
    localparam logic [1:0] COMPUTE = 2'd2;
    localparam logic [1:0] WRITE   = 2'd3;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_STALL_W = 8;
    localparam int TMR_W       = 4;

endpackage

// File: rtl/kpn_adder_firing_ctrl_if.sv
// FIFO-status / strobe bundle between the adder firing controller and
// the surrounding FIFOs; master is the controller side.
interface kpn_adder_firing_ctrl_if #(
    parameter int CNT_W   = 16,
    parameter int STALL_W = 8
);

    logic               enable;
    logic               in1_empty;
    logic               in2_empty;
    logic               out_full;
    logic               rd;
    logic               wr;
    logic               busy;
    logic [CNT_W-1:0]   fire_count;
    logic [STALL_W-1:0] stall_cycles;
    logic               done;

    modport master (
        input  enable, in1_empty, in2_empty, out_full,
        output rd, wr, busy, fire_count, stall_cycles, done
    );

    modport slave (
        output enable, in1_empty, in2_empty, out_full,
        input  rd, wr, busy, fire_count, stall_cycles, done
    );

endinterface

// File: rtl/kpn_adder_firing_ctrl_timer.sv
// kpn_latency_timer: loadable down-counter with a zero flag, shared by
// KPN node controllers to pace compute latency.
module kpn_latency_timer
    import kpn_ctrl_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/kpn_adder_firing_ctrl.sv
// Firing controller for a two-input KPN adder node.
// Optional firing budget enabled by defining FIRE_LIMIT_EN.
module kpn_adder_firing_ctrl
    import kpn_ctrl_pkg::*;
#(
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int STALL_W = DEF_STALL_W
`ifdef FIRE_LIMIT_EN
    ,
    parameter int MAX_FIRINGS = 1000
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    kpn_adder_firing_ctrl_if.master bus
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   fire_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               done_q;
    logic               ready;
    logic               last_fire;
    logic               tmr_zero;
    logic               wr_int;

    assign wr_int = (state == WRITE) && !bus.out_full;

    assign ready = bus.enable && !bus.in1_empty && !bus.in2_empty &&
                   !bus.out_full && !done_q;

`ifdef FIRE_LIMIT_EN
    // This write exhausts the budget: suppress a back-to-back READ too
    assign last_fire = wr_int &&
                       ((fire_cnt + CNT_W'(1)) == CNT_W'(MAX_FIRINGS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else if (last_fire) begin
            done_q <= 1'b1;
        end
    end
`else
    assign last_fire = 1'b0;
    assign done_q    = 1'b0;
`endif

    kpn_latency_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == READ),
        .load_val (TMR_W'(ADD_LAT - 1)),
        .dec      (state == COMPUTE),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = ready ? READ : IDLE;
            READ:    state_nxt = COMPUTE;
            COMPUTE: state_nxt = tmr_zero ? WRITE : COMPUTE;
            WRITE: begin
                if (bus.out_full) begin
                    state_nxt = WRITE;
                end else if (ready && !last_fire) begin
                    state_nxt = READ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_cnt <= '0;
        end else if (wr_int) begin
            fire_cnt <= fire_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == WRITE && bus.out_full && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign bus.rd           = (state == READ);
    assign bus.wr           = wr_int;
    assign bus.busy         = (state != IDLE);
    assign bus.fire_count   = fire_cnt;
    assign bus.stall_cycles = stall_cnt;
    assign bus.done         = done_q;

endmodule
